shift_unit_pipe: RTL and testbench

- Parametrised, pipelined barrel shifter for the EX stage.
- Supersedes the fixed 32-bit, single-mode, combinational arithmetic-right shifter.
- Supports SLL/SRL/SRA/ROR at width XLEN, with a configurable number of register stages.
- Uses a valid/ready handshake on both sides, carries a destination tag, and supports a synchronous flush.

---
 rtl/shift_pkg.sv | 52 +++++
 rtl/shift_unit_pipe_if.sv | 35 +++
 rtl/shift_stage.sv | 91 +++++++++
 rtl/shift_unit_pipe.sv | 92 +++++++++
 tb/tb_shift_unit_pipe.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Contents:
//   shift_op_e   - operation encoding (SLL/SRL/SRA/ROR)
//   SHIFT_MAX_W  - widest supported operand; level logic is evaluated at this
//                  width and the caller keeps its operand zero-extended
//   shift_level  - one log-shifter level: shifts by 2^j when amt_bit is set
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    localparam int unsigned SHIFT_MAX_W = 64;

    // One shifter level. data holds an xlen-bit operand zero-extended to 64
    // bits; the result is returned in the same form. fill is the original
    // operand MSB, used as the SRA fill value at every level.
    function automatic logic [SHIFT_MAX_W-1:0] shift_level(
        input logic [SHIFT_MAX_W-1:0] data,
        input shift_op_e              op,
        input logic                   fill,
        input logic                   amt_bit,
        input int unsigned            j,
        input int unsigned            xlen
    );
        logic [SHIFT_MAX_W-1:0] mask;
        logic [SHIFT_MAX_W-1:0] fill_mask;
        logic [SHIFT_MAX_W-1:0] res;
        int unsigned            s;
        s    = 32'd1 << j;
        mask = (xlen >= 32'd64) ? {SHIFT_MAX_W{1'b1}}
                                : ((64'd1 << xlen) - 64'd1);
        // top s bits of the xlen-wide word
        fill_mask = ({SHIFT_MAX_W{1'b1}} << (xlen - s)) & mask;
        case (op)
            SH_SLL:  res = data << s;
            SH_SRL:  res = data >> s;
            SH_SRA:  res = (data >> s) | (fill ? fill_mask : 64'd0);
            SH_ROR:  res = (data >> s) | (data << (xlen - s));
            default: res = data;
        endcase
        if (amt_bit) begin
            return res & mask;
        end else begin
            return data;
        end
    endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Request/response bundle of the pipelined shifter.
//   in_*  : request side  (valid/ready, op, operand, shift amount, tag)
//   out_* : response side (valid/ready, result, tag)
// master = producer/consumer around the unit, slave = the shifter itself.
interface shift_unit_pipe_if
    import shift_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) ();

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    logic               in_valid;
    logic               in_ready;
    shift_op_e          in_op;
    logic [XLEN-1:0]    in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/shift_stage.sv
// One register slice of the pipelined shifter. Applies levels LVL_LO..LVL_HI
// to the incoming partial result and registers it together with op, shift
// amount, tag, SRA fill bit and valid.
// Ports:
//   clk, rst_n, flush      - clock, async active-low reset, sync kill
//   up_valid/up_ready      - handshake with the previous stage (or requester)
//   up_op/data/shamt/tag/fill - incoming payload
//   dn_valid/dn_ready      - handshake with the next stage (or consumer)
//   dn_op/data/shamt/tag/fill - registered payload
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned LVL_LO  = 0,
    parameter int unsigned LVL_HI  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               up_valid,
    output logic               up_ready,
    input  shift_op_e          up_op,
    input  logic [XLEN-1:0]    up_data,
    input  logic [SHAMT_W-1:0] up_shamt,
    input  logic [TAG_W-1:0]   up_tag,
    input  logic               up_fill,
    output logic               dn_valid,
    input  logic               dn_ready,
    output shift_op_e          dn_op,
    output logic [XLEN-1:0]    dn_data,
    output logic [SHAMT_W-1:0] dn_shamt,
    output logic [TAG_W-1:0]   dn_tag,
    output logic               dn_fill
);

    logic                   valid_r;
    shift_op_e              op_r;
    logic [XLEN-1:0]        data_r;
    logic [SHAMT_W-1:0]     shamt_r;
    logic [TAG_W-1:0]       tag_r;
    logic                   fill_r;
    logic [SHIFT_MAX_W-1:0] lvl_s;
    logic                   load_s;

    // Room here when empty or when the current occupant moves on this cycle
    assign up_ready = !valid_r || dn_ready;
    assign load_s   = up_valid && up_ready;

    // Chain this slice's shifter levels on the incoming partial result
    always_comb begin
        lvl_s = SHIFT_MAX_W'(up_data);
        for (int j = LVL_LO; j <= LVL_HI; j++) begin
            lvl_s = shift_level(lvl_s, up_op, up_fill, up_shamt[j], j, XLEN);
        end
    end

    // Valid and payload registers; flush only clears valid, payload may go stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            op_r    <= SH_SLL;
            data_r  <= '0;
            shamt_r <= '0;
            tag_r   <= '0;
            fill_r  <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else begin
            if (up_ready) begin
                valid_r <= up_valid;
            end
            if (load_s) begin
                op_r    <= up_op;
                data_r  <= lvl_s[XLEN-1:0];
                shamt_r <= up_shamt;
                tag_r   <= up_tag;
                fill_r  <= up_fill;
            end
        end
    end

    assign dn_valid = valid_r;
    assign dn_op    = op_r;
    assign dn_data  = data_r;
    assign dn_shamt = shamt_r;
    assign dn_tag   = tag_r;
    assign dn_fill  = fill_r;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter for the EX stage.
// SHAMT_W log levels are spread over PIPE_STAGES elastic register slices;
// level j lives in slice floor(j*PIPE_STAGES/SHAMT_W). Results leave in
// request order, PIPE_STAGES cycles after acceptance when not stalled.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   flush - synchronous kill of every in-flight op (beats accept and emit)
//   bus   - request/response bundle (slave side)
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    shift_unit_pipe_if.slave bus
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    // Index 0 is the request side; index k+1 is the output of slice k.
    logic [PIPE_STAGES:0]              valid_s;
    logic [PIPE_STAGES:0]              fill_s;
    shift_op_e                         op_s [PIPE_STAGES+1];
    logic [PIPE_STAGES:0][XLEN-1:0]    data_s;
    logic [PIPE_STAGES:0][SHAMT_W-1:0] shamt_s;
    logic [PIPE_STAGES:0][TAG_W-1:0]   tag_s;
    // ready_s[k]: slice k can take a new op; room_s[k]: same, for slice k
    // computed from registered valids so the ready chain has no self-loop.
    logic [PIPE_STAGES-1:0]            ready_s;
    logic [PIPE_STAGES:1]              room_s;
    logic                              unused_s;

    assign valid_s[0] = bus.in_valid;
    assign op_s[0]    = bus.in_op;
    assign data_s[0]  = bus.in_data;
    assign shamt_s[0] = bus.in_shamt;
    assign tag_s[0]   = bus.in_tag;
    assign fill_s[0]  = bus.in_data[XLEN-1];

    // A slice has room if out_ready is high or any later slice is empty
    for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_room
        if (k == PIPE_STAGES) begin : g_last
            assign room_s[k] = bus.out_ready;
        end else begin : g_mid
            assign room_s[k] = bus.out_ready || !(&valid_s[PIPE_STAGES:k+1]);
        end
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        localparam int unsigned LO = (k * SHAMT_W + PIPE_STAGES - 1) / PIPE_STAGES;
        localparam int unsigned HI = ((k + 1) * SHAMT_W + PIPE_STAGES - 1) / PIPE_STAGES - 1;
        shift_stage #(
            .XLEN    (XLEN),
            .SHAMT_W (SHAMT_W),
            .TAG_W   (TAG_W),
            .LVL_LO  (LO),
            .LVL_HI  (HI)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (valid_s[k]),
            .up_ready (ready_s[k]),
            .up_op    (op_s[k]),
            .up_data  (data_s[k]),
            .up_shamt (shamt_s[k]),
            .up_tag   (tag_s[k]),
            .up_fill  (fill_s[k]),
            .dn_valid (valid_s[k+1]),
            .dn_ready (room_s[k+1]),
            .dn_op    (op_s[k+1]),
            .dn_data  (data_s[k+1]),
            .dn_shamt (shamt_s[k+1]),
            .dn_tag   (tag_s[k+1]),
            .dn_fill  (fill_s[k+1])
        );
    end

    assign bus.in_ready  = ready_s[0];
    assign bus.out_valid = valid_s[PIPE_STAGES];
    assign bus.out_data  = data_s[PIPE_STAGES];
    assign bus.out_tag   = tag_s[PIPE_STAGES];

    // Last-slice control fields and inner ready outputs have no consumer
    assign unused_s = ^{ready_s, op_s[PIPE_STAGES], shamt_s[PIPE_STAGES], fill_s[PIPE_STAGES]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe (XLEN=32, PIPE_STAGES=2).
// Expected results come from a plain-arithmetic model and an in-order queue.
module tb_shift_unit_pipe;
    import shift_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PIPE    = 2;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned SHAMT_W = $clog2(XLEN);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    shift_unit_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    shift_unit_pipe #(.XLEN(XLEN), .PIPE_STAGES(PIPE), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [XLEN-1:0]  d;
        logic [TAG_W-1:0] t;
        int               c;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    int   cnum    = 0;
    bit   acc;
    logic seen_ready;

    function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a, input int sh);
        logic [2*XLEN-1:0]        dbl;
        logic signed [2*XLEN-1:0] sx;
        case (op)
            2'd0: return a << sh;
            2'd1: return a >> sh;
            2'd2: begin
                sx = {{XLEN{a[XLEN-1]}}, a};
                sx = sx >>> sh;
                return sx[XLEN-1:0];
            end
            default: begin
                dbl = {a, a};
                dbl = dbl >> sh;
                return dbl[XLEN-1:0];
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle; entered just after a falling edge, returns after the next one.
    task automatic cyc(input bit v, input int op, input logic [XLEN-1:0] d, input int sh,
                       input int tg, input bit ordy, input bit fl, input bit latchk);
        exp_t e;
        bit   emit;
        bus.in_valid  = v;
        bus.in_op     = shift_op_e'(op[1:0]);
        bus.in_data   = d;
        bus.in_shamt  = sh[SHAMT_W-1:0];
        bus.in_tag    = tg[TAG_W-1:0];
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        seen_ready = bus.in_ready;
        acc  = v && seen_ready && !fl;
        emit = bus.out_valid && ordy && !fl;
        check("phantom", {63'd0, bus.out_valid && (q.size() == 0)}, 64'd0);
        if (emit && q.size() != 0) begin
            e = q.pop_front();
            check("data", bus.out_data, e.d);
            check("tag", bus.out_tag, e.t);
            if (latchk) check("latency", 64'(cnum - e.c), PIPE);
        end
        if (fl) q.delete();
        if (acc) begin
            e.d = model(op[1:0], d, sh);
            e.t = tg[TAG_W-1:0];
            e.c = cnum;
            q.push_back(e);
        end
        check("capacity", {63'd0, q.size() <= PIPE}, 64'd1);
        cnum++;
        @(posedge clk);
        @(negedge clk);
        if (fl) check("flush_clears", bus.out_valid, 1'b0);
    endtask

    task automatic idle(input bit ordy, input bit latchk);
        cyc(1'b0, 0, '0, 0, 0, ordy, 1'b0, latchk);
    endtask

    logic [1:0]      d_op  [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic [XLEN-1:0] d_in  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
    int              d_sh  [4] = '{4, 4, 31, 1};
    logic [XLEN-1:0] d_exp [4] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h8000_0000};
    logic [XLEN-1:0] bp_d  [3];
    int              r;
    int              shv;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = SH_SLL;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // reset state
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_tag", bus.out_tag, 64'd0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed ops, one at a time, fixed-latency results
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, int'(d_op[i]), d_in[i], d_sh[i], i + 3, 1'b1, 1'b0, 1'b1);
            idle(1'b1, 1'b1);
            check("dir_valid", bus.out_valid, 1'b1);
            check("dir_data", bus.out_data, d_exp[i]);
            check("dir_tag", bus.out_tag, i + 3);
            idle(1'b1, 1'b1);
        end

        // back-to-back
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, $urandom_range(3), $urandom, $urandom_range(XLEN - 1), i, 1'b1, 1'b0, 1'b1);
            check("b2b_in_ready", seen_ready, 1'b1);
        end
        repeat (3) idle(1'b1, 1'b1);

        // backpressure
        for (int i = 0; i < 3; i++) bp_d[i] = $urandom;
        cyc(1'b1, 2, bp_d[0], 7, 10, 1'b0, 1'b0, 1'b0);
        check("bp_ready0", seen_ready, 1'b1);
        cyc(1'b1, 3, bp_d[1], 9, 11, 1'b0, 1'b0, 1'b0);
        check("bp_ready1", seen_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", bus.out_valid, 1'b1);
            check("bp_hold_data", bus.out_data, model(2'd2, bp_d[0], 7));
            cyc(1'b1, 1, bp_d[2], 13, 12, 1'b0, 1'b0, 1'b0);
            check("bp_ready_low", seen_ready, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1, bp_d[2], 13, 12, 1'b1, 1'b0, 1'b0);
            if (acc) break;
        end
        check("bp_op2_taken", acc, 1'b1);
        repeat (4) idle(1'b1, 1'b0);
        check("bp_drained", q.size(), 64'd0);

        // flush with two ops in flight and a request on the flush cycle
        cyc(1'b1, 0, $urandom, 3, 20, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2, $urandom, 5, 21, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1, $urandom, 6, 22, 1'b1, 1'b1, 1'b0);
        repeat (4) idle(1'b1, 1'b0);

        // asynchronous reset with two ops in flight
        cyc(1'b1, 3, $urandom, 2, 23, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2, 32'h8000_0000, 31, 24, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_data", bus.out_data, 64'd0);
        check("mid_rst_tag", bus.out_tag, 64'd0);
        q.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        repeat (4) idle(1'b1, 1'b0);

        // SRA of the sign bit by XLEN-1
        cyc(1'b1, 2, 32'h8000_0000, XLEN - 1, 25, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 1'b1);
        check("sra_max", bus.out_data, 32'hFFFF_FFFF);
        idle(1'b1, 1'b1);

        // randomized traffic with stalls and occasional flush
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(7);
            if (r == 0) shv = 0;
            else if (r == 1) shv = XLEN - 1;
            else shv = $urandom_range(XLEN - 1);
            cyc($urandom_range(9) < 7, $urandom_range(3), $urandom, shv, $urandom_range(31),
                $urandom_range(9) < 8, $urandom_range(49) == 0, 1'b0);
        end
        repeat (PIPE + 2) idle(1'b1, 1'b0);
        check("drain_empty", q.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
